// File: rtl/cordic_iter_scheduler.sv
// Issues CORDIC shift-index beats for one job under a ready/valid handshake,
// repeating the odd iterations selected by a thermometer repeat mask.
module cordic_iter_scheduler #(
    parameter int CNT_W   = 4,
    parameter int IDX_W   = 5,
    parameter int NREP    = 6,
    parameter int MAX_REQ = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic             mode,
    input  logic             abort,
    input  logic             iter_ready,
    output logic             iter_valid,
    output logic [IDX_W-1:0] iter_idx,
    output logic             iter_rep,
    output logic             last,
    output logic [NREP-1:0]  rep_mask,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             rep_q, rep_d;
    logic             err_q, err_d;
    logic [NREP-1:0]  mask_q, mask_d;

    logic             accept, rangeErr, zeroReq, fire;
    logic             slotBit, repPending, atEnd;
    logic [CNT_W:0]   kHalf;
    logic [NREP-1:0]  maskNew;

    // Thermometer mask of the requested count; the loop bound caps k at NREP.
    always_comb begin
        kHalf   = ({1'b0, n_iter} + (CNT_W+1)'(1)) >> 1;
        maskNew = '0;
        for (int j = 0; j < NREP; j++) begin
            maskNew[j] = (j < int'(kHalf));
        end
    end

    always_comb begin
        slotBit = 1'b0;
        for (int j = 0; j < NREP; j++) begin
            if (int'(idx_q >> 1) == j) begin
                slotBit = mask_q[j];
            end
        end
    end

    assign accept     = (state_q == IDLE) && start;
    assign rangeErr   = int'(n_iter) > MAX_REQ;
    assign zeroReq    = (n_iter == '0);
    assign fire       = (state_q == RUN) && iter_ready;
    assign repPending = !rep_q && mode_q && idx_q[0] && slotBit;
    assign atEnd      = (idx_q == n_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !rangeErr) begin
                    state_d = zeroReq ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (fire && !repPending && atEnd) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort beats a simultaneous handshake, so the beat registers only move without it.
    always_comb begin
        n_d    = n_q;
        idx_d  = idx_q;
        mode_d = mode_q;
        rep_d  = rep_q;
        mask_d = mask_q;
        err_d  = 1'b0;
        if (accept) begin
            if (rangeErr) begin
                err_d  = 1'b1;
                mask_d = '0;
            end else begin
                mask_d = maskNew;
                n_d    = IDX_W'(n_iter);
                mode_d = mode;
                idx_d  = IDX_W'(1);
                rep_d  = 1'b0;
            end
        end else if (fire && !abort) begin
            if (repPending) begin
                rep_d = 1'b1;
            end else if (!atEnd) begin
                idx_d = idx_q + IDX_W'(1);
                rep_d = 1'b0;
            end
        end
    end

    always_comb begin
        iter_valid = (state_q == RUN);
        iter_idx   = iter_valid ? idx_q : '0;
        iter_rep   = iter_valid && rep_q;
        last       = iter_valid && atEnd && !repPending;
        rep_mask   = mask_q;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_cordic_iter_scheduler.sv
// Directed self-checking bench for cordic_iter_scheduler: beat sequences,
// backpressure, range error, zero count, abort and asynchronous reset.
module tb_cordic_iter_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] n_iter;
    logic       mode;
    logic       abort;
    logic       iter_ready;
    logic       iter_valid;
    logic [4:0] iter_idx;
    logic       iter_rep;
    logic       last;
    logic [5:0] rep_mask;
    logic       busy;
    logic       done;
    logic       err;

    int nChecks;
    int nFails;

    int beatIdx[64];
    int beatRep[64];
    int beatLast[64];
    int nBeats;
    int doneAt;
    int holdBad;

    cordic_iter_scheduler #(
        .CNT_W(4), .IDX_W(5), .NREP(6), .MAX_REQ(12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_iter    (n_iter),
        .mode      (mode),
        .abort     (abort),
        .iter_ready(iter_ready),
        .iter_valid(iter_valid),
        .iter_idx  (iter_idx),
        .iter_rep  (iter_rep),
        .last      (last),
        .rep_mask  (rep_mask),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents a start for one edge; returns in the first cycle after acceptance.
    task automatic launch(input logic [3:0] n, input logic m);
        start  = 1'b1;
        n_iter = n;
        mode   = m;
        step();
        start  = 1'b0;
    endtask

    // Records accepted beats until done is seen; ready either high or toggling.
    task automatic collect(input bit toggleReady, input int budget);
        bit         havePrev;
        logic [4:0] pIdx;
        logic       pRep;
        logic       pLast;
        nBeats   = 0;
        doneAt   = -1;
        holdBad  = 0;
        havePrev = 1'b0;
        pIdx     = '0;
        pRep     = 1'b0;
        pLast    = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            iter_ready = toggleReady ? cyc[0] : 1'b1;
            if (havePrev && (iter_valid !== 1'b1 || iter_idx !== pIdx ||
                             iter_rep !== pRep || last !== pLast)) begin
                holdBad++;
            end
            havePrev = 1'b0;
            if (iter_valid === 1'b1 && iter_ready === 1'b0) begin
                havePrev = 1'b1;
                pIdx     = iter_idx;
                pRep     = iter_rep;
                pLast    = last;
            end
            if (iter_valid === 1'b1 && iter_ready === 1'b1 && nBeats < 64) begin
                beatIdx[nBeats]  = int'(iter_idx);
                beatRep[nBeats]  = int'(iter_rep);
                beatLast[nBeats] = int'(last);
                nBeats++;
            end
            if (done === 1'b1) begin
                doneAt = cyc;
                break;
            end
            step();
        end
        iter_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        start      = 1'b0;
        n_iter     = '0;
        mode       = 1'b0;
        abort      = 1'b0;
        iter_ready = 1'b1;
        #12;
        nChecks++;
        if ({iter_valid, iter_idx, iter_rep, last, rep_mask, busy, done, err} !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %b want all zero",
                     {iter_valid, iter_idx, iter_rep, last, rep_mask, busy, done, err});
        end
        rst_n = 1'b1;
        step();
        nChecks++;
        if (busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_n5_mode1;
        int expIdx[8] = '{1, 1, 2, 3, 3, 4, 5, 5};
        int expRep[8] = '{0, 1, 0, 0, 1, 0, 0, 1};
        launch(4'd5, 1'b1);
        nChecks++;
        if (rep_mask !== 6'b000111) begin
            nFails++;
            $display("[TB] FAIL n5_mask: got %b want 000111", rep_mask);
        end
        nChecks++;
        if (busy !== 1'b1 || iter_valid !== 1'b1 || iter_idx !== 5'd1) begin
            nFails++;
            $display("[TB] FAIL n5_first_cycle: busy=%b valid=%b idx=%0d want 1 1 1",
                     busy, iter_valid, iter_idx);
        end
        collect(1'b0, 40);
        nChecks++;
        if (nBeats != 8) begin
            nFails++;
            $display("[TB] FAIL n5_beat_count: got %0d want 8", nBeats);
        end
        for (int b = 0; b < 8; b++) begin
            nChecks++;
            if (b >= nBeats || beatIdx[b] != expIdx[b] || beatRep[b] != expRep[b] ||
                beatLast[b] != int'(b == 7)) begin
                nFails++;
                $display("[TB] FAIL n5_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         b, beatIdx[b], beatRep[b], beatLast[b], expIdx[b], expRep[b], int'(b == 7));
            end
        end
        nChecks++;
        if (doneAt != 9) begin
            nFails++;
            $display("[TB] FAIL n5_done_cycle: got %0d want 9", doneAt);
        end
        step();
        nChecks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL n5_back_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_n12;
        int expIdx[18];
        int expRep[18];
        int k;
        int repCount;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            expIdx[k] = i;
            expRep[k] = 0;
            k++;
            if (i % 2 == 1) begin
                expIdx[k] = i;
                expRep[k] = 1;
                k++;
            end
        end
        launch(4'd12, 1'b1);
        nChecks++;
        if (rep_mask !== 6'b111111) begin
            nFails++;
            $display("[TB] FAIL n12_mask: got %b want 111111", rep_mask);
        end
        collect(1'b0, 60);
        nChecks++;
        if (nBeats != 18) begin
            nFails++;
            $display("[TB] FAIL n12m1_beat_count: got %0d want 18", nBeats);
        end
        for (int b = 0; b < 18; b++) begin
            nChecks++;
            if (b >= nBeats || beatIdx[b] != expIdx[b] || beatRep[b] != expRep[b] ||
                beatLast[b] != int'(b == 17)) begin
                nFails++;
                $display("[TB] FAIL n12m1_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         b, beatIdx[b], beatRep[b], beatLast[b], expIdx[b], expRep[b], int'(b == 17));
            end
        end
        nChecks++;
        if (doneAt != 19) begin
            nFails++;
            $display("[TB] FAIL n12m1_done_cycle: got %0d want 19", doneAt);
        end
        step();
        nChecks++;
        if (busy !== 1'b0 || rep_mask !== 6'b111111) begin
            nFails++;
            $display("[TB] FAIL n12_mask_hold: busy=%b mask=%b want 0 111111", busy, rep_mask);
        end

        launch(4'd12, 1'b0);
        collect(1'b0, 60);
        repCount = 0;
        for (int b = 0; b < nBeats; b++) begin
            repCount += beatRep[b];
        end
        nChecks++;
        if (nBeats != 12 || repCount != 0) begin
            nFails++;
            $display("[TB] FAIL n12m0_count: got beats=%0d reps=%0d want 12 0", nBeats, repCount);
        end
        for (int b = 0; b < 12; b++) begin
            nChecks++;
            if (b >= nBeats || beatIdx[b] != b + 1 || beatLast[b] != int'(b == 11)) begin
                nFails++;
                $display("[TB] FAIL n12m0_beat%0d: got (%0d,last=%0d) want (%0d,last=%0d)",
                         b, beatIdx[b], beatLast[b], b + 1, int'(b == 11));
            end
        end
        nChecks++;
        if (doneAt != 13) begin
            nFails++;
            $display("[TB] FAIL n12m0_done_cycle: got %0d want 13", doneAt);
        end
        step();
    endtask

    task automatic test_range_err;
        launch(4'd13, 1'b1);
        nChecks++;
        if (err !== 1'b1 || busy !== 1'b0 || rep_mask !== 6'b0 || iter_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL range_err: err=%b busy=%b mask=%b valid=%b want 1 0 000000 0",
                     err, busy, rep_mask, iter_valid);
        end
        step();
        nChecks++;
        if (err !== 1'b0 || busy !== 1'b0 || iter_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL range_err_after: err=%b busy=%b valid=%b want 0 0 0",
                     err, busy, iter_valid);
        end
    endtask

    task automatic test_zero;
        launch(4'd0, 1'b1);
        nChecks++;
        if (done !== 1'b1 || iter_valid !== 1'b0 || rep_mask !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL zero_done: done=%b valid=%b mask=%b want 1 0 000000",
                     done, iter_valid, rep_mask);
        end
        step();
        nChecks++;
        if (done !== 1'b0 || busy !== 1'b0 || iter_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL zero_after: done=%b busy=%b valid=%b want 0 0 0",
                     done, busy, iter_valid);
        end
    endtask

    task automatic test_backpressure;
        int expIdx[5] = '{1, 1, 2, 3, 3};
        int expRep[5] = '{0, 1, 0, 0, 1};
        launch(4'd3, 1'b1);
        collect(1'b1, 40);
        nChecks++;
        if (nBeats != 5) begin
            nFails++;
            $display("[TB] FAIL bp_beat_count: got %0d want 5", nBeats);
        end
        for (int b = 0; b < 5; b++) begin
            nChecks++;
            if (b >= nBeats || beatIdx[b] != expIdx[b] || beatRep[b] != expRep[b] ||
                beatLast[b] != int'(b == 4)) begin
                nFails++;
                $display("[TB] FAIL bp_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         b, beatIdx[b], beatRep[b], beatLast[b], expIdx[b], expRep[b], int'(b == 4));
            end
        end
        nChecks++;
        if (holdBad != 0) begin
            nFails++;
            $display("[TB] FAIL bp_hold: got %0d unstable stalls want 0", holdBad);
        end
        nChecks++;
        if (doneAt != 10) begin
            nFails++;
            $display("[TB] FAIL bp_done_cycle: got %0d want 10", doneAt);
        end
        step();
    endtask

    task automatic test_back_to_back_abort;
        iter_ready = 1'b1;
        launch(4'd5, 1'b1);
        step();
        start  = 1'b1;
        n_iter = 4'd2;
        mode   = 1'b0;
        step();
        start = 1'b0;
        nChecks++;
        if (iter_valid !== 1'b1 || iter_idx !== 5'd2 || iter_rep !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL run_start_ignored: valid=%b idx=%0d rep=%b want 1 2 0",
                     iter_valid, iter_idx, iter_rep);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        nChecks++;
        if (busy !== 1'b0 || iter_valid !== 1'b0 || done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL abort_idle: busy=%b valid=%b done=%b want 0 0 0",
                     busy, iter_valid, done);
        end
        step();
        nChecks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL abort_no_done: done=%b busy=%b want 0 0", done, busy);
        end
        launch(4'd2, 1'b1);
        collect(1'b0, 20);
        nChecks++;
        if (nBeats != 3 || beatIdx[0] != 1 || beatRep[0] != 0 || beatIdx[1] != 1 ||
            beatRep[1] != 1 || beatIdx[2] != 2 || beatRep[2] != 0 || beatLast[2] != 1) begin
            nFails++;
            $display("[TB] FAIL restart_n2: got %0d beats (%0d,%0d)(%0d,%0d)(%0d,%0d) want 3 (1,0)(1,1)(2,0)",
                     nBeats, beatIdx[0], beatRep[0], beatIdx[1], beatRep[1], beatIdx[2], beatRep[2]);
        end
        nChecks++;
        if (doneAt != 4) begin
            nFails++;
            $display("[TB] FAIL restart_done_cycle: got %0d want 4", doneAt);
        end
        step();
    endtask

    task automatic test_async_reset;
        launch(4'd12, 1'b0);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({iter_valid, iter_idx, iter_rep, last, rep_mask, busy, done, err} !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL async_reset: got %b want all zero",
                     {iter_valid, iter_idx, iter_rep, last, rep_mask, busy, done, err});
        end
        step();
        nChecks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL async_reset_hold: busy=%b done=%b want 0 0", busy, done);
        end
        #4;
        rst_n = 1'b1;
        step();
        launch(4'd3, 1'b0);
        collect(1'b0, 20);
        nChecks++;
        if (nBeats != 3 || beatIdx[0] != 1 || beatIdx[1] != 2 || beatIdx[2] != 3 ||
            beatRep[0] + beatRep[1] + beatRep[2] != 0 || beatLast[2] != 1) begin
            nFails++;
            $display("[TB] FAIL post_reset_job: got %0d beats idx %0d %0d %0d want 3 beats idx 1 2 3",
                     nBeats, beatIdx[0], beatIdx[1], beatIdx[2]);
        end
        nChecks++;
        if (doneAt != 4) begin
            nFails++;
            $display("[TB] FAIL post_reset_done_cycle: got %0d want 4", doneAt);
        end
        step();
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        test_reset();
        test_n5_mode1();
        test_n12();
        test_range_err();
        test_zero();
        test_backpressure();
        test_back_to_back_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
